// File: rtl/window_trap_ctrl.sv
// Register-window / trap sequencer: evaluates SAVE, RESTORE, trap entry and RETT against the
// latched PSR and WIM, then drives the PSR write port and TBR.tt with a req/ack handshake.
module window_trap_ctrl #(
  parameter int unsigned NWINDOWS = 8
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic [31:0]         psr_in,
  input  logic [NWINDOWS-1:0] wim_in,
  input  logic                req,
  input  logic [1:0]          op,
  input  logic [7:0]          ext_tt,
  output logic                psr_we,
  output logic [3:0]          icc_out,
  output logic [2:0]          cwp_out,
  output logic [1:0]          trap_out,
  output logic [7:0]          tt_out,
  output logic                tt_we,
  output logic                ack,
  output logic                err_mode
);

  localparam logic [2:0] CwpMax    = 3'(NWINDOWS - 1);
  localparam logic [1:0] OpSave    = 2'd0;
  localparam logic [1:0] OpRestore = 2'd1;
  localparam logic [1:0] OpTrap    = 2'd2;
  localparam logic [1:0] OpRett    = 2'd3;
  localparam logic [1:0] CodeNone  = 2'd0;
  localparam logic [1:0] CodeTrap  = 2'd1;
  localparam logic [1:0] CodeRett  = 2'd2;
  localparam logic [7:0] TtIllegal = 8'h02;
  localparam logic [7:0] TtPriv    = 8'h03;
  localparam logic [7:0] TtOvf     = 8'h05;
  localparam logic [7:0] TtUnf     = 8'h06;

  typedef enum logic [2:0] {StIdle, StEval, StCommit, StAck, StError} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [2:0]          cwp_q, cwp_d;
  logic                et_q, et_d;
  logic                s_q, s_d;
  logic [3:0]          icc_q, icc_d;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic [7:0]          ext_tt_q, ext_tt_d;

  logic                psr_we_q, psr_we_d;
  logic                tt_we_q, tt_we_d;
  logic [1:0]          trap_out_q, trap_out_d;
  logic [2:0]          cwp_out_q, cwp_out_d;
  logic [3:0]          icc_out_q, icc_out_d;
  logic [7:0]          tt_out_q, tt_out_d;
  logic                ack_q, ack_d;
  logic                err_mode_q, err_mode_d;

  logic                unused_psr;
  assign unused_psr = ^{psr_in[31:24], psr_in[19:8], psr_in[6], psr_in[4:3]};

  // Widen WIM to the full 3-bit CWP index space so any NWINDOWS indexes cleanly.
  logic [7:0] wim_ext;
  assign wim_ext = 8'(wim_q);

  logic [2:0] dec, inc, ev_cwp;
  logic [1:0] ev_code;
  logic [7:0] ev_tt;
  logic       ev_trap, ev_err;

  always_comb begin
    dec     = (cwp_q == 3'd0) ? CwpMax : cwp_q - 3'd1;
    inc     = (cwp_q == CwpMax) ? 3'd0 : cwp_q + 3'd1;
    ev_trap = 1'b0;
    ev_tt   = 8'h00;
    ev_cwp  = cwp_q;
    ev_code = CodeNone;
    unique case (op_q)
      OpSave: begin
        if (wim_ext[dec]) begin
          ev_trap = 1'b1;
          ev_tt   = TtOvf;
        end else begin
          ev_cwp = dec;
        end
      end
      OpRestore: begin
        if (wim_ext[inc]) begin
          ev_trap = 1'b1;
          ev_tt   = TtUnf;
        end else begin
          ev_cwp = inc;
        end
      end
      OpTrap: begin
        ev_trap = 1'b1;
        ev_tt   = ext_tt_q;
      end
      OpRett: begin
        if (!s_q) begin
          ev_trap = 1'b1;
          ev_tt   = TtPriv;
        end else if (et_q) begin
          ev_trap = 1'b1;
          ev_tt   = TtIllegal;
        end else if (wim_ext[inc]) begin
          ev_trap = 1'b1;
          ev_tt   = TtUnf;
        end else begin
          ev_cwp  = inc;
          ev_code = CodeRett;
        end
      end
    endcase
    // Trap entry never checks WIM; with traps disabled it is fatal.
    if (ev_trap) begin
      ev_cwp  = dec;
      ev_code = CodeTrap;
    end
    ev_err = ev_trap & ~et_q;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cwp_d      = cwp_q;
    et_d       = et_q;
    s_d        = s_q;
    icc_d      = icc_q;
    wim_d      = wim_q;
    ext_tt_d   = ext_tt_q;
    psr_we_d   = 1'b0;
    tt_we_d    = 1'b0;
    trap_out_d = CodeNone;
    ack_d      = 1'b0;
    cwp_out_d  = cwp_out_q;
    icc_out_d  = icc_out_q;
    tt_out_d   = tt_out_q;
    err_mode_d = err_mode_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          op_d     = op;
          cwp_d    = psr_in[2:0];
          et_d     = psr_in[5];
          s_d      = psr_in[7];
          icc_d    = psr_in[23:20];
          wim_d    = wim_in;
          ext_tt_d = ext_tt;
          state_d  = StEval;
        end
      end
      StEval: begin
        if (ev_err) begin
          err_mode_d = 1'b1;
          state_d    = StError;
        end else begin
          psr_we_d   = 1'b1;
          cwp_out_d  = ev_cwp;
          trap_out_d = ev_code;
          icc_out_d  = icc_q;
          if (ev_trap) begin
            tt_we_d  = 1'b1;
            tt_out_d = ev_tt;
          end
          state_d = StCommit;
        end
      end
      StCommit: begin
        ack_d   = 1'b1;
        state_d = StAck;
      end
      StAck:   state_d = StIdle;
      StError: err_mode_d = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_q    <= StIdle;
      op_q       <= 2'd0;
      cwp_q      <= 3'd0;
      et_q       <= 1'b0;
      s_q        <= 1'b0;
      icc_q      <= 4'd0;
      wim_q      <= '0;
      ext_tt_q   <= 8'h00;
      psr_we_q   <= 1'b0;
      tt_we_q    <= 1'b0;
      trap_out_q <= 2'd0;
      cwp_out_q  <= 3'd0;
      icc_out_q  <= 4'd0;
      tt_out_q   <= 8'h00;
      ack_q      <= 1'b0;
      err_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cwp_q      <= cwp_d;
      et_q       <= et_d;
      s_q        <= s_d;
      icc_q      <= icc_d;
      wim_q      <= wim_d;
      ext_tt_q   <= ext_tt_d;
      psr_we_q   <= psr_we_d;
      tt_we_q    <= tt_we_d;
      trap_out_q <= trap_out_d;
      cwp_out_q  <= cwp_out_d;
      icc_out_q  <= icc_out_d;
      tt_out_q   <= tt_out_d;
      ack_q      <= ack_d;
      err_mode_q <= err_mode_d;
    end
  end

  assign psr_we   = psr_we_q;
  assign tt_we    = tt_we_q;
  assign trap_out = trap_out_q;
  assign cwp_out  = cwp_out_q;
  assign icc_out  = icc_out_q;
  assign tt_out   = tt_out_q;
  assign ack      = ack_q;
  assign err_mode = err_mode_q;

endmodule

// File: tb/tb_window_trap_ctrl.sv
// Bench for window_trap_ctrl: directed plan cases plus randomized requests checked against a
// arithmetic reference model of the window/trap rules.
module tb_window_trap_ctrl;

  localparam int NW = 8;

  logic          Clk = 1'b0;
  logic          Clr;
  logic [31:0]   psr_in;
  logic [NW-1:0] wim_in;
  logic          req;
  logic [1:0]    op;
  logic [7:0]    ext_tt;
  logic          psr_we, tt_we, ack, err_mode;
  logic [3:0]    icc_out;
  logic [2:0]    cwp_out;
  logic [1:0]    trap_out;
  logic [7:0]    tt_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_cwp;
  logic [3:0] exp_icc;

  typedef struct packed {
    logic       err;
    logic       tt_we;
    logic [1:0] code;
    logic [2:0] cwp;
    logic [7:0] tt;
  } exp_t;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] cwp;
    logic       et;
    logic       s;
    logic [7:0] wim;
    logic [7:0] tt;
  } vec_t;

  window_trap_ctrl #(.NWINDOWS(NW)) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .psr_in   (psr_in),
    .wim_in   (wim_in),
    .req      (req),
    .op       (op),
    .ext_tt   (ext_tt),
    .psr_we   (psr_we),
    .icc_out  (icc_out),
    .cwp_out  (cwp_out),
    .trap_out (trap_out),
    .tt_out   (tt_out),
    .tt_we    (tt_we),
    .ack      (ack),
    .err_mode (err_mode)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: window moves modulo NW, traps take the window below the current one.
  function automatic exp_t model(input logic [1:0] o, input int cwp, input logic et,
                                 input logic s, input logic [NW-1:0] w, input logic [7:0] t);
    exp_t r;
    int dec, inc;
    bit trap;
    logic [7:0] tt;
    dec = (cwp + NW - 1) % NW;
    inc = (cwp + 1) % NW;
    r = '0;
    trap = 1'b0;
    tt = 8'h00;
    case (o)
      2'd0: if (w[dec]) begin trap = 1'b1; tt = 8'h05; end else r.cwp = 3'(dec);
      2'd1: if (w[inc]) begin trap = 1'b1; tt = 8'h06; end else r.cwp = 3'(inc);
      2'd2: begin trap = 1'b1; tt = t; end
      default: begin
        if (!s) begin trap = 1'b1; tt = 8'h03; end
        else if (et) begin trap = 1'b1; tt = 8'h02; end
        else if (w[inc]) begin trap = 1'b1; tt = 8'h06; end
        else begin r.cwp = 3'(inc); r.code = 2'd2; end
      end
    endcase
    if (trap) begin
      if (!et) r.err = 1'b1;
      else begin
        r.cwp = 3'(dec);
        r.code = 2'd1;
        r.tt_we = 1'b1;
        r.tt = tt;
      end
    end
    return r;
  endfunction

  // Present one request for one edge, then scramble inputs to prove they were latched.
  task automatic send(input logic [1:0] o, input logic [2:0] c, input logic et, input logic s,
                      input logic [3:0] icc, input logic [NW-1:0] w, input logic [7:0] t);
    logic [31:0] p;
    @(negedge Clk);
    p = $urandom;
    p[2:0] = c;
    p[5] = et;
    p[7] = s;
    p[23:20] = icc;
    psr_in = p;
    wim_in = w;
    op = o;
    ext_tt = t;
    req = 1'b1;
    @(posedge Clk);
    #1;
    req = 1'b0;
    psr_in = $urandom;
    wim_in = NW'($urandom);
    ext_tt = 8'($urandom);
    op = 2'($urandom);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Clr = 1'b0;
    @(negedge Clk);
    Clr = 1'b1;
    exp_cwp = 3'd0;
    exp_icc = 4'd0;
  endtask

  task automatic test_reset();
    Clr = 1'b0;
    req = 1'b0;
    psr_in = '0;
    wim_in = '0;
    op = 2'd0;
    ext_tt = 8'h00;
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({psr_we, tt_we, ack, err_mode, cwp_out, trap_out, icc_out, tt_out} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_state: outputs=%h required 0",
               {psr_we, tt_we, ack, err_mode, cwp_out, trap_out, icc_out, tt_out});
    end
    Clr = 1'b1;
    exp_cwp = 3'd0;
    exp_icc = 4'd0;
  endtask

  task automatic test_windows();
    vec_t tbl [7];
    exp_t e;
    logic [3:0] icc;
    tbl[0] = {2'd0, 3'd3, 1'b1, 1'b1, 8'h00, 8'h00};
    tbl[1] = {2'd0, 3'd0, 1'b1, 1'b1, 8'h80, 8'h00};
    tbl[2] = {2'd1, 3'd7, 1'b1, 1'b1, 8'h01, 8'h00};
    tbl[3] = {2'd1, 3'd7, 1'b1, 1'b1, 8'h00, 8'h00};
    tbl[4] = {2'd2, 3'd5, 1'b1, 1'b1, 8'h00, 8'h80};
    tbl[5] = {2'd3, 3'd4, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[6] = {2'd3, 3'd4, 1'b1, 1'b1, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) begin
      icc = 4'($urandom);
      e = model(tbl[i].op, int'(tbl[i].cwp), tbl[i].et, tbl[i].s, tbl[i].wim, tbl[i].tt);
      send(tbl[i].op, tbl[i].cwp, tbl[i].et, tbl[i].s, icc, tbl[i].wim, tbl[i].tt);
      @(negedge Clk);
      n_cmp++;
      if ({psr_we, tt_we, ack} !== 3'b000) begin
        n_err++;
        $display("FAIL dir_eval #%0d: we/tt_we/ack=%b required 000", i, {psr_we, tt_we, ack});
      end
      @(negedge Clk);
      exp_cwp = e.cwp;
      exp_icc = icc;
      n_cmp++;
      if ({psr_we, tt_we, trap_out, cwp_out, icc_out} !== {1'b1, e.tt_we, e.code, exp_cwp, exp_icc})
      begin
        n_err++;
        $display("FAIL dir_commit #%0d: we,tt_we,code,cwp,icc=%b required %b", i,
                 {psr_we, tt_we, trap_out, cwp_out, icc_out},
                 {1'b1, e.tt_we, e.code, exp_cwp, exp_icc});
      end
      if (e.tt_we) begin
        n_cmp++;
        if (tt_out !== e.tt) begin
          n_err++;
          $display("FAIL dir_tt #%0d: tt_out=%h required %h", i, tt_out, e.tt);
        end
      end
      @(negedge Clk);
      n_cmp++;
      if ({psr_we, tt_we, trap_out, ack} !== 5'b00001) begin
        n_err++;
        $display("FAIL dir_ack #%0d: we,tt_we,code,ack=%b required 00001", i,
                 {psr_we, tt_we, trap_out, ack});
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_error();
    send(2'd2, 3'd2, 1'b0, 1'b1, 4'h9, '0, 8'h11);
    @(negedge Clk);
    @(negedge Clk);
    n_cmp++;
    if ({psr_we, tt_we, ack, err_mode} !== 4'b0001) begin
      n_err++;
      $display("FAIL err_enter: we,tt_we,ack,err=%b required 0001", {psr_we, tt_we, ack, err_mode});
    end
    for (int k = 0; k < 8; k++) begin
      req = 1'($urandom);
      op = 2'($urandom);
      @(negedge Clk);
      n_cmp++;
      if ({psr_we, tt_we, ack, err_mode} !== 4'b0001) begin
        n_err++;
        $display("FAIL err_sticky %0d: we,tt_we,ack,err=%b required 0001", k,
                 {psr_we, tt_we, ack, err_mode});
      end
    end
    req = 1'b0;
    do_reset();
    n_cmp++;
    if ({err_mode, psr_we, ack, cwp_out, tt_out} !== 14'd0) begin
      n_err++;
      $display("FAIL err_clear: err,we,ack,cwp,tt=%b required 0", {err_mode, psr_we, ack, cwp_out, tt_out});
    end
    send(2'd0, 3'd3, 1'b1, 1'b1, 4'h2, '0, 8'h00);
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({psr_we, cwp_out} !== {1'b1, 3'd2}) begin
      n_err++;
      $display("FAIL err_recover: we,cwp=%b required 1010", {psr_we, cwp_out});
    end
    exp_cwp = 3'd2;
    exp_icc = 4'h2;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    send(2'd0, 3'd4, 1'b1, 1'b1, 4'h7, '0, 8'h00);
    @(negedge Clk);
    Clr = 1'b0;
    @(negedge Clk);
    Clr = 1'b1;
    exp_cwp = 3'd0;
    exp_icc = 4'd0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({psr_we, tt_we, ack, err_mode, cwp_out, trap_out, icc_out, tt_out} !== 23'd0) begin
        n_err++;
        $display("FAIL mid_reset %0d: outputs=%h required 0", k,
                 {psr_we, tt_we, ack, err_mode, cwp_out, trap_out, icc_out, tt_out});
      end
      @(negedge Clk);
    end
    send(2'd1, 3'd4, 1'b1, 1'b1, 4'hc, '0, 8'h00);
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({psr_we, cwp_out, icc_out} !== {1'b1, 3'd5, 4'hc}) begin
      n_err++;
      $display("FAIL mid_next: we,cwp,icc=%b required %b", {psr_we, cwp_out, icc_out},
               {1'b1, 3'd5, 4'hc});
    end
    @(negedge Clk);
    n_cmp++;
    if (ack !== 1'b1) begin
      n_err++;
      $display("FAIL mid_next_ack: ack=%b required 1", ack);
    end
    exp_cwp = 3'd5;
    exp_icc = 4'hc;
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] p;
    @(negedge Clk);
    p = $urandom;
    p[2:0] = 3'd6;
    p[5] = 1'b1;
    p[7] = 1'b1;
    psr_in = p;
    wim_in = '0;
    op = 2'd0;
    req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      n_cmp++;
      if ({psr_we, ack} !== {c % 4 == 2, c % 4 == 3}) begin
        n_err++;
        $display("FAIL b2b cycle %0d: we,ack=%b required %b", c, {psr_we, ack},
                 {c % 4 == 2, c % 4 == 3});
      end
      if (c % 4 == 2) begin
        n_cmp++;
        if (cwp_out !== 3'd5) begin
          n_err++;
          $display("FAIL b2b_cwp cycle %0d: cwp_out=%0d required 5", c, cwp_out);
        end
      end
    end
    req = 1'b0;
    exp_cwp = 3'd5;
    exp_icc = p[23:20];
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_random();
    exp_t e;
    logic [1:0] o;
    logic [2:0] c;
    logic et, s;
    logic [3:0] icc;
    logic [NW-1:0] w;
    logic [7:0] t;
    for (int i = 0; i < 300; i++) begin
      o = 2'($urandom);
      c = 3'($urandom_range(NW - 1));
      et = ($urandom_range(9) != 0);
      s = ($urandom_range(7) != 0);
      icc = 4'($urandom);
      w = ($urandom_range(1) == 1) ? NW'($urandom) : '0;
      t = 8'($urandom);
      e = model(o, int'(c), et, s, w, t);
      send(o, c, et, s, icc, w, t);
      @(negedge Clk);
      n_cmp++;
      if ({psr_we, tt_we, ack} !== 3'b000) begin
        n_err++;
        $display("FAIL rnd_eval #%0d: we/tt_we/ack=%b required 000", i, {psr_we, tt_we, ack});
      end
      @(negedge Clk);
      if (!e.err) begin
        exp_cwp = e.cwp;
        exp_icc = icc;
      end
      n_cmp++;
      if ({psr_we, tt_we, trap_out, cwp_out, icc_out, err_mode} !==
          {~e.err, e.tt_we, e.code, exp_cwp, exp_icc, e.err}) begin
        n_err++;
        $display("FAIL rnd_commit #%0d op=%0d cwp=%0d: got %b required %b", i, o, c,
                 {psr_we, tt_we, trap_out, cwp_out, icc_out, err_mode},
                 {~e.err, e.tt_we, e.code, exp_cwp, exp_icc, e.err});
      end
      if (e.tt_we) begin
        n_cmp++;
        if (tt_out !== e.tt) begin
          n_err++;
          $display("FAIL rnd_tt #%0d: tt_out=%h required %h", i, tt_out, e.tt);
        end
      end
      @(negedge Clk);
      n_cmp++;
      if ({psr_we, tt_we, trap_out, ack, err_mode} !== {4'b0000, ~e.err, e.err}) begin
        n_err++;
        $display("FAIL rnd_ack #%0d: we,tt_we,code,ack,err=%b required %b", i,
                 {psr_we, tt_we, trap_out, ack, err_mode}, {4'b0000, ~e.err, e.err});
      end
      if (e.err) begin
        do_reset();
        n_cmp++;
        if ({err_mode, cwp_out, icc_out} !== 8'd0) begin
          n_err++;
          $display("FAIL rnd_clear #%0d: err,cwp,icc=%b required 0", i, {err_mode, cwp_out, icc_out});
        end
      end else begin
        @(negedge Clk);
        n_cmp++;
        if (ack !== 1'b0) begin
          n_err++;
          $display("FAIL rnd_ackdrop #%0d: ack=%b required 0", i, ack);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_windows();
    test_error();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
